// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// ALU/write-back codes and instruction field positions.
package controle_multiciclo_pkg;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_ALU  = 3'd1,
    CL_LI   = 3'd2,
    CL_LW   = 3'd3,
    CL_SW   = 3'd4,
    CL_JMP  = 3'd5,
    CL_HALT = 3'd6,
    CL_ILL  = 3'd7
  } op_class_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  // byte0 = {op, rd, rsv}; byte1 = {rs1, rs2, rsv} or imm8
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 1;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 2;

endpackage

// File: rtl/controle_multiciclo_decodificador_instr.sv
// Combinational instruction decoder: IR bytes -> op class, register fields,
// ALU operation and legal flag. Reserved bits are deliberately ignored.
module decodificador_instr
  import controle_multiciclo_pkg::*;
(
  input  logic [7:0] ir0,
  input  logic [7:0] ir1,
  output op_class_t  op_class,
  output logic [1:0] alu_op,
  output logic [2:0] rd,
  output logic [2:0] rs1,
  output logic [2:0] rs2,
  output logic       legal
);

  logic unused_rsv;
  assign unused_rsv = ^{ir0[0], ir1[1:0]};

  // Field extraction and opcode classification
  always_comb begin
    rd       = ir0[RD_MSB:RD_LSB];
    rs1      = ir1[RS1_MSB:RS1_LSB];
    rs2      = ir1[RS2_MSB:RS2_LSB];
    alu_op   = ALU_ADD;
    op_class = CL_ILL;
    legal    = 1'b1;
    case (ir0[OP_MSB:OP_LSB])
      OP_NOP:  op_class = CL_NOP;
      OP_ADD:  begin op_class = CL_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CL_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CL_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CL_ALU; alu_op = ALU_OR;  end
      OP_LI:   op_class = CL_LI;
      OP_LW:   op_class = CL_LW;
      OP_SW:   op_class = CL_SW;
      OP_JMP:  op_class = CL_JMP;
      OP_HALT: op_class = CL_HALT;
      default: begin op_class = CL_ILL; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetches 2-byte instructions, sequences register
// bank reads/writes, ALU, write-back mux and the data-memory handshake.
//
// state  | meaning
// FETCH0 | present PC, latch byte0 (only when Run)
// FETCH1 | latch byte1
// DECODE | classify; JMP/NOP/illegal finish here
// READ   | drive rs1/rs2 to the register bank
// EXEC   | ALU operation selected
// MEM    | data-memory request held until MemReady or timeout
// WB     | one-cycle register write
// HALT   | stopped until reset
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [3:0] MEM_TMO  = 4'd15
)(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  output logic [7:0] InstrAddr,
  input  logic [7:0] InstrByte,
  output logic [2:0] RegLido1,
  output logic [2:0] RegLido2,
  output logic [2:0] RegEscr,
  output logic       RegWrite,
  output logic [1:0] AluOp,
  output logic [1:0] WbSel,
  output logic [7:0] Imm,
  output logic       MemReq,
  output logic       MemWe,
  input  logic       MemReady,
  output logic       Halted,
  output logic       Erro
);

  state_t     state, state_nxt;
  logic [7:0] pc, ir0, ir1;
  logic [3:0] tmo_cnt;
  logic       erro;
  logic       tmo_hit;
  op_class_t  op_class;
  logic [1:0] alu_op;
  logic [2:0] rd, rs1, rs2;
  logic       legal;

  decodificador_instr u_dec (
    .ir0      (ir0),
    .ir1      (ir1),
    .op_class (op_class),
    .alu_op   (alu_op),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .legal    (legal)
  );

  // A zero MEM_TMO disables the timeout entirely
  assign tmo_hit = (MEM_TMO != 4'd0) && (tmo_cnt == 4'd1);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_FETCH0;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH0: if (Run) state_nxt = ST_FETCH1;
      ST_FETCH1: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CL_ALU, CL_LW, CL_SW: state_nxt = ST_READ;
          CL_LI:                state_nxt = ST_WB;
          CL_HALT:              state_nxt = ST_HALT;
          default:              state_nxt = ST_FETCH0;
        endcase
      end
      ST_READ:   state_nxt = (op_class == CL_ALU) ? ST_EXEC : ST_MEM;
      ST_EXEC:   state_nxt = ST_WB;
      ST_MEM: begin
        if (MemReady)     state_nxt = (op_class == CL_LW) ? ST_WB : ST_FETCH0;
        else if (tmo_hit) state_nxt = ST_FETCH0;
      end
      ST_WB:     state_nxt = ST_FETCH0;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH0;
    endcase
  end

  // PC, instruction register, sticky error and memory timeout down-counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc      <= PC_RESET;
      ir0     <= 8'h00;
      ir1     <= 8'h00;
      tmo_cnt <= 4'd0;
      erro    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH0: if (Run) begin
          ir0 <= InstrByte;
          pc  <= pc + 8'd1;
        end
        ST_FETCH1: begin
          ir1 <= InstrByte;
          pc  <= pc + 8'd1;
        end
        ST_DECODE: begin
          if (op_class == CL_JMP) pc <= ir1;
          if (!legal) erro <= 1'b1;
        end
        ST_READ: tmo_cnt <= MEM_TMO;
        ST_MEM: if (!MemReady) begin
          if (tmo_hit) erro <= 1'b1;
          else         tmo_cnt <= tmo_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registered IR only
  always_comb begin
    InstrAddr = pc;
    Imm       = ir1;
    Erro      = erro;
    Halted    = (state == ST_HALT);
    RegLido1  = 3'd0;
    RegLido2  = 3'd0;
    RegEscr   = 3'd0;
    RegWrite  = 1'b0;
    AluOp     = ALU_ADD;
    WbSel     = WB_ALU;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    if ((state inside {ST_READ, ST_EXEC, ST_MEM, ST_WB}) &&
        (op_class inside {CL_ALU, CL_LW, CL_SW})) begin
      RegLido1 = rs1;
      RegLido2 = rs2;
    end
    if ((state inside {ST_EXEC, ST_WB}) && (op_class == CL_ALU))
      AluOp = alu_op;
    if (state == ST_MEM) begin
      MemReq = 1'b1;
      MemWe  = (op_class == CL_SW);
    end
    if (state == ST_WB) begin
      RegEscr  = rd;
      RegWrite = 1'b1;
      case (op_class)
        CL_LI:   WbSel = WB_IMM;
        CL_LW:   WbSel = WB_MEM;
        default: WbSel = WB_ALU;
      endcase
    end
  end

endmodule
